bus_interconnect: RTL and testbench
===================================

Name: bus_interconnect

Overview:
Parametrised single-master, N-slave memory-mapped bus fabric that replaces the hand-written chip-select and read-mux logic in the SoC top.
- Decodes the CPU bus address against per-slave base/mask pairs.
- Sequences each transaction through a registered FSM.
- Supports slaves with arbitrary wait states.
- Returns an error response for unmapped addresses or slave timeouts instead of silently reading 0.

Parameters:
NUM_SLAVES, 4, number of slave channels (1..16)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
SLAVE_BASE, {32'hF1000000,32'hF0000000,32'h00010000,32'h00000000}, packed NUM_SLAVES*ADDR_WIDTH bases, slave 0 in LSBs
SLAVE_MASK, {32'hFFFFFFF8,32'hFFFFFFF0,32'hFFFF0000,32'hFFFF0000}, packed NUM_SLAVES*ADDR_WIDTH match masks
TIMEOUT_CYCLES, 16, max cycles spent waiting for s_ready; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
m_valid  in  1  master request; held high until m_ready is seen
m_write  in  1  1 = write, 0 = read
m_addr  in  ADDR_WIDTH  master address
m_wdata  in  DATA_WIDTH  master write data
m_rdata  out  DATA_WIDTH  registered read data
m_ready  out  1  transaction complete; level-held while m_valid stays high
m_error  out  1  qualifies m_ready: unmapped access or timeout
s_sel  out  NUM_SLAVES  one-hot slave select
s_write  out  1  registered copy of m_write
s_addr  out  ADDR_WIDTH  registered copy of m_addr
s_wdata  out  DATA_WIDTH  registered copy of m_wdata
s_rdata  in  NUM_SLAVES*DATA_WIDTH  packed slave read data
s_ready  in  NUM_SLAVES  per-slave completion
err_addr  out  ADDR_WIDTH  address of the most recent errored transaction
err_count  out  8  saturating error counter

Behaviour:
- Reset (reset==0 at a clk edge):
  - State becomes IDLE.
  - s_sel, m_ready, m_error, m_rdata, s_write, s_addr, s_wdata, err_addr and err_count all become 0.
  - Applies from any state; an in-flight access is abandoned with no response.
- Decode: hit[i] = ((m_addr & MASK[i]) == BASE[i]). Overlapping hits resolve to the lowest index.
- IDLE:
  - On m_valid==1, register m_addr, m_wdata and m_write into s_addr, s_wdata and s_write.
  - Any hit: latch the one-hot select into s_sel; go to ACCESS; clear the wait counter.
  - No hit: go to RESP with m_error=1 and m_rdata=0; update err_addr and err_count.
- ACCESS:
  - s_sel is held stable and the wait counter increments every cycle.
  - s_ready[sel]==1: m_rdata <= s_rdata[sel] for reads, 0 for writes; m_error <= 0; s_sel <= 0; go to RESP.
  - Else, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: s_sel <= 0; m_error <= 1; m_rdata <= 0; update err_addr and err_count; go to RESP.
  - s_ready from non-selected slaves is ignored.
  - If m_valid drops mid-ACCESS, the access still completes; slave side effects are not cancelled.
- RESP:
  - m_ready=1.
  - Stays in RESP with m_ready held while m_valid==1.
  - On the first cycle m_valid==0, go to IDLE with m_ready <= 0 and m_error <= 0.
  - A master that dropped m_valid early therefore sees a single-cycle m_ready pulse.
  - No new request is accepted until IDLE is reached, so a held m_valid can never double-issue.
- Latency, counted from the m_valid accept edge:
  - Mapped access with a zero-wait slave (s_ready high while selected): m_ready at +2 cycles.
  - Each slave wait cycle adds 1.
  - Unmapped access: m_ready at +1 cycle.
- err_count saturates at 255. err_addr updates on every error, including after saturation.
- Counter width is clog2(TIMEOUT_CYCLES+1); there is no wrap before the compare.

Test Plan:
- Read 0x00000004, slave 0 ready immediately with s_rdata0=0xDEADBEEF -> s_sel=0001 for 1 cycle; m_ready at accept+2; m_rdata=0xDEADBEEF; m_error=0.
- Write 0x00010008 data 0x12345678, slave 1 asserts s_ready after 3 wait cycles -> s_sel=0010 for 4 cycles; s_wdata=0x12345678; s_write=1; m_ready at accept+5; m_rdata=0.
- Read 0x80000000 (unmapped) -> s_sel stays 0; m_ready at accept+1; m_error=1; err_addr=0x80000000; err_count=1.
- Read 0xF0000004, slave 2 never ready, TIMEOUT_CYCLES=16 -> s_sel=0100 for 16 cycles then drops; m_ready with m_error=1; err_count increments.
- m_valid held high for 10 cycles after m_ready -> m_ready high all 10 cycles; exactly one s_sel pulse; FSM returns to IDLE only after m_valid falls.
- reset=0 asserted during ACCESS wait -> next edge s_sel=0, m_ready=0, err_count=0; a fresh read after release completes normally.

Source files
------------

// File: rtl/bus_interconnect.sv
// Single-master, N-slave memory-mapped bus fabric: base/mask address decode,
// registered transaction FSM, wait-state support and error response on unmapped/timeout.
module bus_interconnect #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'hF1000000, 32'hF0000000, 32'h00010000, 32'h00000000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hFFFFFFF8, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFF0000},
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             m_valid,
  input  logic                             m_write,
  input  logic [ADDR_WIDTH-1:0]            m_addr,
  input  logic [DATA_WIDTH-1:0]            m_wdata,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             m_ready,
  output logic                             m_error,
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic                             s_write,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  output logic [ADDR_WIDTH-1:0]            err_addr,
  output logic [7:0]                       err_count
);

  localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int                CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_wait_cnt;

  logic [NUM_SLAVES-1:0]   w_hit_sel;
  logic                    w_hit;
  logic [DATA_WIDTH-1:0]   w_sel_rdata;
  logic                    w_sel_ready;
  logic [7:0]              w_err_count_next;

  // Walk from the highest index down so the lowest matching slave wins on overlap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_hit_sel = '0;
    w_hit     = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        w_hit_sel    = '0;
        w_hit_sel[i] = 1'b1;
        w_hit        = 1'b1;
      end
    end
  end

  // s_sel is one-hot, so an AND-OR mux is sufficient for the read data path.
  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_sel[i]) w_sel_rdata = w_sel_rdata | s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_sel_ready      = |(s_ready & s_sel);
  assign w_err_count_next = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and active-low.
    if (!reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      s_sel      <= '0;
      m_ready    <= 1'b0;
      m_error    <= 1'b0;
      m_rdata    <= '0;
      s_write    <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      err_addr   <= '0;
      err_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m_valid) begin
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_write <= m_write;
            if (w_hit) begin
              s_sel      <= w_hit_sel;
              r_wait_cnt <= '0;
              r_state    <= ACCESS;
            end else begin
              m_ready   <= 1'b1;
              m_error   <= 1'b1;
              m_rdata   <= '0;
              err_addr  <= m_addr;
              err_count <= w_err_count_next;
              r_state   <= RESP;
            end
          end
        end
        ACCESS: begin
          if (w_sel_ready) begin
            m_rdata <= s_write ? '0 : w_sel_rdata;
            m_ready <= 1'b1;
            m_error <= 1'b0;
            s_sel   <= '0;
            r_state <= RESP;
          end else if (TIMEOUT_EN && (r_wait_cnt == CNT_LAST)) begin
            m_rdata   <= '0;
            m_ready   <= 1'b1;
            m_error   <= 1'b1;
            s_sel     <= '0;
            err_addr  <= s_addr;
            err_count <= w_err_count_next;
            r_state   <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          // Hold the response until the master withdraws its request.
          if (!m_valid) begin
            m_ready <= 1'b0;
            m_error <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect: scoreboard queue of expected responses,
// behavioural wait-state slaves, immediate-assertion checks and one summary line.
module tb_bus_interconnect;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              m_valid = 1'b0;
  logic              m_write = 1'b0;
  logic [AW-1:0]     m_addr = '0;
  logic [DW-1:0]     m_wdata = '0;
  logic [DW-1:0]     m_rdata;
  logic              m_ready;
  logic              m_error;
  logic [NS-1:0]     s_sel;
  logic              s_write;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [NS*DW-1:0]  s_rdata;
  logic [NS-1:0]     s_ready = '0;
  logic [AW-1:0]     err_addr;
  logic [7:0]        err_count;

  int errors = 0;
  int checks = 0;
  int exp_err_cnt = 0;
  int wait_cfg [NS] = '{0, 0, 0, 0};
  int sel_cycles = 0;
  logic [NS-1:0] noise_ready = '0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    logic [NS-1:0] sel;
    int            sel_cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign s_rdata = {32'hCAFEF00D, 32'h0BADF00D, 32'h5555AAAA, 32'hDEADBEEF};

  bus_interconnect dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error),
    .s_sel(s_sel), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .err_addr(err_addr), .err_count(err_count)
  );

  // Slave model: selected slave raises s_ready after wait_cfg cycles; noise drives unselected slaves.
  always @(negedge clk) begin
    if (s_sel == '0) sel_cycles = 0;
    else             sel_cycles = sel_cycles + 1;
    s_ready = noise_ready & ~s_sel;
    for (int i = 0; i < NS; i++) begin
      if (s_sel[i] && sel_cycles > wait_cfg[i]) s_ready[i] = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic err,
                        input int lat, input logic [NS-1:0] sel, input int sel_cyc, input int hold);
    exp_t e;
    int   n = 0;
    int   sc = 0;
    bit   got = 1'b0;
    @(negedge clk);
    m_valid = 1'b1;
    m_write = wr;
    m_addr  = addr;
    m_wdata = wd;
    sb.push_back('{rdata: rd, err: err, lat: lat, sel: sel, sel_cyc: sel_cyc});
    if (err && exp_err_cnt < 255) exp_err_cnt++;
    while (!got && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        check({tag, " s_addr"}, s_addr, addr);
        check({tag, " s_write"}, s_write, wr);
        if (wr) check({tag, " s_wdata"}, s_wdata, wd);
      end
      if (s_sel != '0) begin
        sc++;
        check({tag, " s_sel"}, s_sel, sel);
      end
      got = m_ready;
    end
    e = sb.pop_front();
    check({tag, " m_ready seen"}, got, 1'b1);
    check({tag, " latency"}, n, e.lat);
    check({tag, " m_rdata"}, m_rdata, e.rdata);
    check({tag, " m_error"}, m_error, e.err);
    check({tag, " s_sel cycles"}, sc, e.sel_cyc);
    check({tag, " err_count"}, err_count, exp_err_cnt);
    if (e.err) check({tag, " err_addr"}, err_addr, addr);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold m_ready"}, m_ready, 1'b1);
      check({tag, " hold s_sel"}, s_sel, '0);
    end
    m_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " m_ready drop"}, m_ready, 1'b0);
    check({tag, " m_error drop"}, m_error, 1'b0);
  endtask

  initial begin
    int rdy_cnt;
    int sel_cnt;
    int first_rdy;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst m_ready", m_ready, 1'b0);
    check("rst m_error", m_error, 1'b0);
    check("rst m_rdata", m_rdata, '0);
    check("rst s_sel", s_sel, '0);
    check("rst s_write", s_write, 1'b0);
    check("rst s_addr", s_addr, '0);
    check("rst s_wdata", s_wdata, '0);
    check("rst err_addr", err_addr, '0);
    check("rst err_count", err_count, '0);
    reset = 1'b1;

    do_txn("rd_s0", 1'b0, 32'h0000_0004, '0, 32'hDEADBEEF, 1'b0, 2, 4'b0001, 1, 0);
    wait_cfg[1] = 3;
    do_txn("wr_s1", 1'b1, 32'h0001_0008, 32'h12345678, '0, 1'b0, 5, 4'b0010, 4, 0);
    do_txn("unmapped", 1'b0, 32'h8000_0000, '0, '0, 1'b1, 1, 4'b0000, 0, 0);
    wait_cfg[2] = 1000;
    noise_ready = 4'b0001;
    do_txn("timeout", 1'b0, 32'hF000_0004, '0, '0, 1'b1, 17, 4'b0100, 16, 0);
    noise_ready = '0;
    do_txn("hold", 1'b0, 32'h0000_FFFC, '0, 32'hDEADBEEF, 1'b0, 2, 4'b0001, 1, 10);
    wait_cfg[3] = 1;
    do_txn("rd_s3", 1'b0, 32'hF100_0004, '0, 32'hCAFEF00D, 1'b0, 3, 4'b1000, 2, 0);
    do_txn("s3_edge", 1'b0, 32'hF100_0008, '0, '0, 1'b1, 1, 4'b0000, 0, 0);
    do_txn("gap", 1'b1, 32'h0002_0000, 32'h1, '0, 1'b1, 1, 4'b0000, 0, 0);

    // Master withdraws m_valid mid-access: access completes, m_ready is a one-cycle pulse.
    @(negedge clk);
    m_valid = 1'b1;
    m_write = 1'b1;
    m_addr  = 32'h0001_0010;
    m_wdata = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    m_valid = 1'b0;
    sel_cnt   = (s_sel != '0) ? 1 : 0;
    rdy_cnt   = 0;
    first_rdy = 0;
    for (int n = 2; n <= 13; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (s_sel != '0) sel_cnt++;
      if (m_ready) begin
        rdy_cnt++;
        if (first_rdy == 0) first_rdy = n;
        check("early m_error", m_error, 1'b0);
      end
    end
    check("early ready cycles", rdy_cnt, 1);
    check("early latency", first_rdy, 5);
    check("early s_sel cycles", sel_cnt, 4);

    for (int i = 0; i < 260; i++) begin
      do_txn("sat", 1'b0, 32'h8000_0000 + 32'(i * 16), '0, '0, 1'b1, 1, 4'b0000, 0, 0);
    end
    check("sat err_count", err_count, 8'hFF);

    do_txn("rd_s3_b", 1'b0, 32'hF100_0000, '0, 32'hCAFEF00D, 1'b0, 3, 4'b1000, 2, 0);

    // Reset in the middle of a waiting access.
    @(negedge clk);
    m_valid = 1'b1;
    m_write = 1'b0;
    m_addr  = 32'hF000_0004;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid s_sel", s_sel, 4'b0100);
    reset   = 1'b0;
    m_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid rst s_sel", s_sel, '0);
    check("mid rst m_ready", m_ready, 1'b0);
    check("mid rst err_count", err_count, '0);
    check("mid rst err_addr", err_addr, '0);
    check("mid rst m_rdata", m_rdata, '0);
    reset       = 1'b1;
    exp_err_cnt = 0;
    sb.delete();
    do_txn("post_rst", 1'b0, 32'h0000_0010, '0, 32'hDEADBEEF, 1'b0, 2, 4'b0001, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish (errors=%0d of %0d checks)", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
